// File: rtl/param_mac_pkg.sv
// ---------------------------------------------------------------------------
// param_mac_pkg
// Shared definitions for the sequential multiply-accumulate block.
//   mac_state_t : control states of the top-level sequencer
//   count_w()   : width of the multiplier bit-index counter for a given
//                 operand width (at least one bit)
// ---------------------------------------------------------------------------
package param_mac_pkg;

    // Encodings are fixed so that state dumps from older builds still decode.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } mac_state_t;

    // The counter must be able to address bits 0..op_w-1. A degenerate
    // one-bit operand would give $clog2 == 0, so one bit is the floor.
    function automatic int count_w(input int op_w);
        return (op_w > 1) ? $clog2(op_w) : 1;
    endfunction

endpackage

// File: rtl/param_seq_mac_shift_add_mul.sv
// ---------------------------------------------------------------------------
// shift_add_mul
// Iterative unsigned multiplier: one shift-add per step, LSB of the
// multiplier first. Holds the operand registers, the partial product and
// the bit counter.
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset
//   load         : capture operands, clear partial product and counter
//   step         : perform one shift-add iteration
//   multiplicand : unsigned multiplicand (OP_W bits)
//   multiplier   : unsigned multiplier   (OP_W bits)
//   product      : partial / final product (2*OP_W bits)
//   count        : index of the multiplier bit handled by the next step
//   last         : the next step is the final one
// ---------------------------------------------------------------------------
module shift_add_mul
    import param_mac_pkg::*;
#(
    parameter int OP_W = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic                       step,
    input  logic [OP_W-1:0]            multiplicand,
    input  logic [OP_W-1:0]            multiplier,
    output logic [2*OP_W-1:0]          product,
    output logic [count_w(OP_W)-1:0]   count,
    output logic                       last
);

    localparam int CNT_W = count_w(OP_W);

    logic [2*OP_W-1:0] mcand_sh;
    logic [OP_W-1:0]   mplier_sh;
    logic [2*OP_W-1:0] partial;

    // The multiplicand walks left and the multiplier walks right, so every
    // step only ever inspects bit 0 of the multiplier and adds the already
    // aligned multiplicand. The counter wraps back to 0 after the final
    // step so it reads 0 whenever no multiplication is running.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_sh  <= '0;
            mplier_sh <= '0;
            partial   <= '0;
            count     <= '0;
        end else if (load) begin
            mcand_sh  <= {{OP_W{1'b0}}, multiplicand};
            mplier_sh <= multiplier;
            partial   <= '0;
            count     <= '0;
        end else if (step) begin
            if (mplier_sh[0]) begin
                partial <= partial + mcand_sh;
            end
            mcand_sh  <= mcand_sh << 1;
            mplier_sh <= mplier_sh >> 1;
            count     <= last ? '0 : count + CNT_W'(1);
        end
    end

    assign last    = (count == CNT_W'(OP_W - 1));
    assign product = partial;

endmodule

// File: rtl/param_seq_mac.sv
// ---------------------------------------------------------------------------
// param_seq_mac
// Sequential multiply-accumulate. An accepted operand pair is multiplied
// over OP_W cycles by shift_add_mul, then added to the accumulator in a
// single ACC cycle. Latency is fixed: acceptance at edge N gives the new
// result after edge N+OP_W+1.
//
// Build option
//   PARAM_MAC_SATURATE_EN : when defined, an overflowing add clamps the
//                           accumulator to all-ones; otherwise it wraps.
//                           overflow_o is sticky in both builds.
//
// Ports
//   clk_i                 : clock, rising edge
//   reset_i               : synchronous active-high reset (highest priority)
//   multiplicand_i        : unsigned multiplicand
//   multiplier_i          : unsigned multiplier
//   valid_i               : operand pair present
//   clear_i               : zero accumulator and overflow flag
//   ready_o               : block can accept an operand pair (IDLE)
//   result_o              : accumulator value
//   updating_acc_result_o : accumulate cycle in progress
//   fetching_input_o      : operand pair accepted this cycle
//   count_o               : multiplier bit index being processed
//   overflow_o            : sticky accumulator overflow
// ---------------------------------------------------------------------------
module param_seq_mac
    import param_mac_pkg::*;
#(
    parameter int OP_W  = 5,
    parameter int ACC_W = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [OP_W-1:0]            multiplicand_i,
    input  logic [OP_W-1:0]            multiplier_i,
    input  logic                       valid_i,
    input  logic                       clear_i,
    output logic                       ready_o,
    output logic [ACC_W-1:0]           result_o,
    output logic                       updating_acc_result_o,
    output logic                       fetching_input_o,
    output logic [count_w(OP_W)-1:0]   count_o,
    output logic                       overflow_o
);

    mac_state_t          state;
    logic                accept;
    logic                mul_last;
    logic [2*OP_W-1:0]   product;
    logic [ACC_W:0]      product_ext;
    logic [ACC_W:0]      sum;
    logic [ACC_W-1:0]    acc;
    logic                overflow;

    assign accept = valid_i && (state == IDLE);

    shift_add_mul #(
        .OP_W (OP_W)
    ) u_mul (
        .clk          (clk_i),
        .reset        (reset_i),
        .load         (accept),
        .step         (state == MUL),
        .multiplicand (multiplicand_i),
        .multiplier   (multiplier_i),
        .product      (product),
        .count        (count_o),
        .last         (mul_last)
    );

    // Sequencer: the MUL phase length comes entirely from the counter, so
    // zero operands take exactly as long as any other pair.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= accept   ? MUL : IDLE;
                MUL:     state <= mul_last ? ACC : MUL;
                ACC:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // One extra bit on the adder exposes the carry out of the top
    // accumulator bit, which is the overflow condition.
    assign product_ext = (ACC_W + 1)'(product);
    assign sum         = {1'b0, acc} + product_ext;

    // Accumulator and sticky overflow. A clear during ACC still lets the
    // finishing product land, but onto zero, so it can never overflow.
    // A clear together with an accepted pair in IDLE zeroes the
    // accumulator now and the product is added onto that zero later.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (state == ACC) begin
            if (clear_i) begin
                acc      <= product_ext[ACC_W-1:0];
                overflow <= 1'b0;
            end else if (sum[ACC_W]) begin
`ifdef PARAM_MAC_SATURATE_EN
                acc      <= '1;
`else
                acc      <= sum[ACC_W-1:0];
`endif
                overflow <= 1'b1;
            end else begin
                acc      <= sum[ACC_W-1:0];
            end
        end else if (clear_i) begin
            acc      <= '0;
            overflow <= 1'b0;
        end
    end

    assign ready_o               = (state == IDLE);
    assign updating_acc_result_o = (state == ACC);
    assign fetching_input_o      = accept && !reset_i;
    assign result_o              = acc;
    assign overflow_o            = overflow;

endmodule
